// File: rtl/ubksa_sub_pipe_7_0_9_0.sv
// Pipelined 10-bit minus 8-bit Kogge-Stone subtractor with valid/ready on both sides.
// Optional macro UBKSA_SUB_PIPE_MID_REG_EN inserts a register stage after prefix level 2.
module ubksa_sub_pipe_7_0_9_0 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] X,
  input  logic [9:0] Y,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [9:0] D,
  output logic       BORROW,
  output logic       OUT_VALID,
  input  logic       OUT_READY
);

  // One Kogge-Stone level; packs {G, P}. Bits below the span pass through unchanged.
  function automatic logic [19:0] ksLevel(input logic [9:0] g, input logic [9:0] p,
                                          input int unsigned span);
    logic [9:0] gn;
    logic [9:0] pn;
    gn = g | (p & (g << span));
    pn = p & ~((~p) << span);
    return {gn, pn};
  endfunction

  // Sum formation with carry-in fixed at 1; packs {C10, S}.
  function automatic logic [10:0] sumForm(input logic [9:0] g4, input logic [9:0] p4,
                                          input logic [9:0] p0);
    logic [9:0] s;
    s[0]   = ~p0[0];
    s[9:1] = (g4[8:0] | p4[8:0]) ^ p0[9:1];
    return {g4[9] | p4[9], s};
  endfunction

  logic [9:0]  w_zn;
  logic [9:0]  w_g0;
  logic [9:0]  w_p0;
  logic        w_accept;
  logic        w_advA;
  logic        w_advZ;
  logic        w_loadZ;
  logic [19:0] w_l1;
  logic [19:0] w_l2;
  logic [19:0] w_l3;
  logic [19:0] w_l4;
  logic [10:0] w_sum;

  logic        r_aValid;
  logic [9:0]  r_aG;
  logic [9:0]  r_aP;
  logic        r_zValid;
  logic [9:0]  r_zD;
  logic        r_zBorrow;

  assign w_zn = ~{2'b00, X};
  assign w_g0 = Y & w_zn;
  assign w_p0 = Y ^ w_zn;

  assign w_advZ   = r_zValid & OUT_READY;
  assign IN_READY = ~RST & (~r_aValid | w_advA);
  assign w_accept = IN_VALID & IN_READY;

  assign w_l1 = ksLevel(r_aG, r_aP, 1);
  assign w_l2 = ksLevel(w_l1[19:10], w_l1[9:0], 2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_aValid <= 1'b0;
      r_aG     <= '0;
      r_aP     <= '0;
    end else begin
      r_aValid <= w_accept | (r_aValid & ~w_advA);
      if (w_accept) begin
        r_aG <= w_g0;
        r_aP <= w_p0;
      end
    end
  end

`ifdef UBKSA_SUB_PIPE_MID_REG_EN
  logic       w_advM;
  logic       r_mValid;
  logic [9:0] r_mG;
  logic [9:0] r_mP;
  logic [9:0] r_mP0;

  assign w_advM  = r_mValid & (~r_zValid | w_advZ);
  assign w_advA  = r_aValid & (~r_mValid | w_advM);
  assign w_loadZ = w_advM;

  // P0 travels alongside G2/P2 because the final XOR still needs it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mValid <= 1'b0;
      r_mG     <= '0;
      r_mP     <= '0;
      r_mP0    <= '0;
    end else begin
      r_mValid <= w_advA | (r_mValid & ~w_advM);
      if (w_advA) begin
        r_mG  <= w_l2[19:10];
        r_mP  <= w_l2[9:0];
        r_mP0 <= r_aP;
      end
    end
  end

  assign w_l3  = ksLevel(r_mG, r_mP, 4);
  assign w_l4  = ksLevel(w_l3[19:10], w_l3[9:0], 8);
  assign w_sum = sumForm(w_l4[19:10], w_l4[9:0], r_mP0);
`else
  assign w_advA  = r_aValid & (~r_zValid | w_advZ);
  assign w_loadZ = w_advA;

  assign w_l3  = ksLevel(w_l2[19:10], w_l2[9:0], 4);
  assign w_l4  = ksLevel(w_l3[19:10], w_l3[9:0], 8);
  assign w_sum = sumForm(w_l4[19:10], w_l4[9:0], r_aP);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_zValid  <= 1'b0;
      r_zD      <= '0;
      r_zBorrow <= 1'b0;
    end else begin
      r_zValid <= w_loadZ | (r_zValid & ~w_advZ);
      if (w_loadZ) begin
        r_zD      <= w_sum[9:0];
        r_zBorrow <= ~w_sum[10];
      end
    end
  end

  assign D         = r_zD;
  assign BORROW    = r_zBorrow;
  assign OUT_VALID = r_zValid;

endmodule

// File: tb/tb_ubksa_sub_pipe_7_0_9_0.sv
// Self-checking bench for ubksa_sub_pipe_7_0_9_0: directed table, streaming, backpressure,
// mid-stream reset and random traffic against an arithmetic reference queue.
module tb_ubksa_sub_pipe_7_0_9_0;

`ifdef UBKSA_SUB_PIPE_MID_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] X;
  logic [9:0] Y;
  logic       IN_VALID;
  logic       IN_READY;
  logic [9:0] D;
  logic       BORROW;
  logic       OUT_VALID;
  logic       OUT_READY;

  ubksa_sub_pipe_7_0_9_0 dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .BORROW(BORROW), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] x;
    logic [9:0] y;
    logic [9:0] d;
    logic       b;
  } vec_t;

  typedef struct {
    logic [9:0] d;
    logic       b;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   emitCount = 0;
  bit   monEn = 1'b0;
  res_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [9:0] y, input logic v);
    X = x;
    Y = y;
    IN_VALID = v;
  endtask

  function automatic res_t refModel(input logic [7:0] x, input logic [9:0] y);
    res_t r;
    int diff;
    diff = int'(y) - int'(x);
    if (diff < 0) diff += 1024;
    r.d = diff[9:0];
    r.b = (x > y);
    return r;
  endfunction

  // Handshakes are evaluated at the falling edge; they describe the transfer on the next rising edge.
  always @(negedge CLK) begin
    if (monEn && !RST) begin
      if (expQ.size() == 0) begin
        checkOutput("noStaleOut", OUT_VALID, 0);
      end else if (OUT_VALID) begin
        checkOutput("outD", D, expQ[0].d);
        checkOutput("outBorrow", BORROW, expQ[0].b);
        if (OUT_READY) begin
          void'(expQ.pop_front());
          emitCount++;
        end
      end
      if (IN_VALID && IN_READY) expQ.push_back(refModel(X, Y));
    end
  end

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || OUT_VALID) && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("drainQueue", expQ.size(), 0);
  endtask

  vec_t vecs[7];
  logic [7:0] bpX[4];
  logic [9:0] bpY[4];

  initial begin
    int lat;
    int sent;
    int base;
    int first;
    int last;
    int ones;

    vecs[0] = '{x: 8'd200, y: 10'd500,  d: 10'd300,  b: 1'b0};
    vecs[1] = '{x: 8'd9,   y: 10'd5,    d: 10'd1020, b: 1'b1};
    vecs[2] = '{x: 8'd255, y: 10'd255,  d: 10'd0,    b: 1'b0};
    vecs[3] = '{x: 8'd0,   y: 10'd1023, d: 10'd1023, b: 1'b0};
    vecs[4] = '{x: 8'd255, y: 10'd0,    d: 10'd769,  b: 1'b1};
    vecs[5] = '{x: 8'd0,   y: 10'd0,    d: 10'd0,    b: 1'b0};
    vecs[6] = '{x: 8'd1,   y: 10'd0,    d: 10'd1023, b: 1'b1};

    RST = 1'b1;
    OUT_READY = 1'b1;
    applyStimulus(8'd3, 10'd7, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstInReady", IN_READY, 0);
    checkOutput("rstOutValid", OUT_VALID, 0);
    checkOutput("rstD", D, 0);
    checkOutput("rstBorrow", BORROW, 0);
    applyStimulus(8'd0, 10'd0, 1'b0);
    RST = 1'b0;
    #1;
    checkOutput("idleInReady", IN_READY, 1);
    monEn = 1'b1;
    @(posedge CLK); #1;

    // Directed vectors; latency counts the accept edge as cycle 1.
    for (int i = 0; i < 7; i++) begin
      checkOutput("vecInReady", IN_READY, 1);
      applyStimulus(vecs[i].x, vecs[i].y, 1'b1);
      @(posedge CLK); #1;
      applyStimulus(8'd0, 10'd0, 1'b0);
      lat = 1;
      while (!OUT_VALID && lat < 10) begin
        @(posedge CLK); #1;
        lat++;
      end
      checkOutput("vecLatency", lat, LAT);
      checkOutput("vecD", D, vecs[i].d);
      checkOutput("vecBorrow", BORROW, vecs[i].b);
      @(posedge CLK); #1;
    end
    waitDrain();

    // 16 back-to-back pairs must come out as one unbroken run of OUT_VALID.
    first = -1; last = -1; ones = 0;
    for (int c = 0; c < 16 + LAT + 3; c++) begin
      applyStimulus(8'($urandom), 10'($urandom), c < 16);
      @(negedge CLK);
      if (c < 16) checkOutput("streamInReady", IN_READY, 1);
      if (OUT_VALID) begin
        if (first < 0) first = c;
        last = c;
        ones++;
      end
      @(posedge CLK); #1;
    end
    checkOutput("streamCount", ones, 16);
    checkOutput("streamContiguous", last - first, 15);
    waitDrain();

    // Backpressure: pipe fills to LAT entries, then IN_READY must drop.
    bpX[0] = 8'd17;  bpY[0] = 10'd900;
    bpX[1] = 8'd250; bpY[1] = 10'd3;
    bpX[2] = 8'd128; bpY[2] = 10'd128;
    bpX[3] = 8'd1;   bpY[3] = 10'd1000;
    base = emitCount;
    OUT_READY = 1'b0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(bpX[sent < 4 ? sent : 0], bpY[sent < 4 ? sent : 0], sent < 4);
      @(negedge CLK);
      if (IN_VALID && IN_READY) sent++;
      @(posedge CLK); #1;
    end
    checkOutput("bpAccepted", sent, LAT);
    checkOutput("bpInReadyLow", IN_READY, 0);
    checkOutput("bpOutValid", OUT_VALID, 1);
    OUT_READY = 1'b1;
    #1;
    checkOutput("bpInReadyRelease", IN_READY, 1);
    for (int c = 0; c < 20 && sent < 4; c++) begin
      applyStimulus(bpX[sent], bpY[sent], 1'b1);
      @(negedge CLK);
      if (IN_READY) sent++;
      @(posedge CLK); #1;
    end
    applyStimulus(8'd0, 10'd0, 1'b0);
    checkOutput("bpAllSent", sent, 4);
    waitDrain();
    checkOutput("bpEmitted", emitCount - base, 4);

    // Reset with two results in flight.
    OUT_READY = 1'b0;
    applyStimulus(8'd10, 10'd20, 1'b1);
    @(posedge CLK); #1;
    applyStimulus(8'd30, 10'd40, 1'b1);
    @(posedge CLK); #1;
    monEn = 1'b0;
    applyStimulus(8'd100, 10'd50, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("midRstOutValid", OUT_VALID, 0);
    checkOutput("midRstD", D, 0);
    checkOutput("midRstBorrow", BORROW, 0);
    checkOutput("midRstInReady", IN_READY, 0);
    expQ.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    checkOutput("postRstOutValid", OUT_VALID, 0);
    checkOutput("postRstInReady", IN_READY, 1);
    base = emitCount;
    monEn = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(8'd0, 10'd0, 1'b0);
    OUT_READY = 1'b1;
    waitDrain();
    checkOutput("postRstEmitted", emitCount - base, 1);

    // Random traffic with random downstream readiness.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(8'($urandom), 10'($urandom), $urandom_range(0, 3) != 0);
      OUT_READY = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    applyStimulus(8'd0, 10'd0, 1'b0);
    OUT_READY = 1'b1;
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
